// File: rtl/der_org_stage_pkg.sv
// Shared drawing-engine definitions for the origin staging path:
// command-entry record layout, field offsets and default queue depth.
package der_org_stage_pkg;

  localparam int ORG_W      = 32;
  localparam int PS_W       = 2;
  localparam int ENTRY_W    = 67;
  localparam int SD_OFF     = 0;
  localparam int PS_OFF     = 1;
  localparam int DORG_OFF   = 3;
  localparam int SORG_OFF   = 35;
  localparam int QDEPTH_DEF = 2;

  typedef struct packed {
    logic [ORG_W-1:0] sorg;
    logic [ORG_W-1:0] dorg;
    logic [PS_W-1:0]  ps_sel;
    logic             sd_sel;
  } org_entry_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [ORG_W-1:0] sorg,
    input logic [ORG_W-1:0] dorg,
    input logic [PS_W-1:0]  ps_sel,
    input logic             sd_sel
  );
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[SORG_OFF +: ORG_W] = sorg;
    e[DORG_OFF +: ORG_W] = dorg;
    e[PS_OFF   +: PS_W]  = ps_sel;
    e[SD_OFF]            = sd_sel;
    return e;
  endfunction

endpackage

// File: rtl/der_org_fifo.sv
// Stage-1 command queue: DEPTH-entry storage with wrap-bit pointers.
// Storage is not reset; only the pointers are.
module der_org_fifo
  import der_org_stage_pkg::*;
#(
  parameter int DEPTH = QDEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               wr_ok;
  logic               rd_ok;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/der_org_stage.sv
// Origin staging for the drawing engine: stage-1 command queue feeding a
// registered stage-2 origin set with busy/go handshake and sticky overflow.
module der_org_stage
  import der_org_stage_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic             de_clk,
  input  logic             de_rstn,
  input  logic             push_1,
  input  logic [ORG_W-1:0] sorg_1,
  input  logic [ORG_W-1:0] dorg_1,
  input  logic [PS_W-1:0]  ps_sel_1,
  input  logic             sd_sel_1,
  input  logic             done_2,
  output logic             rdy_1,
  output logic [ORG_W-1:0] mf_sorg_2,
  output logic [ORG_W-1:0] mf_dorg_2,
  output logic [PS_W-1:0]  ps_sel_2,
  output logic             sd_selector_2,
  output logic             busy_2,
  output logic             go_2,
  output logic             ovf
);

  logic               full;
  logic               empty;
  logic               load;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] head;
  org_entry_t         head_e;

  assign in_entry = pack_entry(sorg_1, dorg_1, ps_sel_1, sd_sel_1);
  assign head_e   = org_entry_t'(head);
  assign rdy_1    = ~full;
  assign load     = (~busy_2 | done_2) & ~empty;

  der_org_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (de_clk),
    .rst_n   (de_rstn),
    .wr_en   (push_1),
    .wr_data (in_entry),
    .rd_en   (load),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // Stage 2: head entry lands here; data holds when the engine drains the queue.
  always_ff @(posedge de_clk or negedge de_rstn) begin
    if (!de_rstn) begin
      mf_sorg_2     <= '0;
      mf_dorg_2     <= '0;
      ps_sel_2      <= '0;
      sd_selector_2 <= 1'b0;
      busy_2        <= 1'b0;
      go_2          <= 1'b0;
      ovf           <= 1'b0;
    end else begin
      go_2 <= load;
      ovf  <= ovf | (push_1 & full);
      if (load) begin
        mf_sorg_2     <= head_e.sorg;
        mf_dorg_2     <= head_e.dorg;
        ps_sel_2      <= head_e.ps_sel;
        sd_selector_2 <= head_e.sd_sel;
        busy_2        <= 1'b1;
      end else if (done_2) begin
        busy_2 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_der_org_stage.sv
// Randomized and directed bench for der_org_stage against a queue-level model.
module tb_der_org_stage;

  localparam int QD = 2;

  logic        de_clk = 1'b0;
  logic        de_rstn;
  logic        push_1;
  logic [31:0] sorg_1, dorg_1;
  logic [1:0]  ps_sel_1;
  logic        sd_sel_1;
  logic        done_2;
  logic        rdy_1;
  logic [31:0] mf_sorg_2, mf_dorg_2;
  logic [1:0]  ps_sel_2;
  logic        sd_selector_2;
  logic        busy_2, go_2, ovf;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: pending commands and the command currently in stage 2.
  logic [66:0] q[$];
  logic [66:0] m_s2;
  bit          m_busy, m_go, m_ovf;

  der_org_stage #(.QDEPTH(QD)) dut (
    .de_clk        (de_clk),
    .de_rstn       (de_rstn),
    .push_1        (push_1),
    .sorg_1        (sorg_1),
    .dorg_1        (dorg_1),
    .ps_sel_1      (ps_sel_1),
    .sd_sel_1      (sd_sel_1),
    .done_2        (done_2),
    .rdy_1         (rdy_1),
    .mf_sorg_2     (mf_sorg_2),
    .mf_dorg_2     (mf_dorg_2),
    .ps_sel_2      (ps_sel_2),
    .sd_selector_2 (sd_selector_2),
    .busy_2        (busy_2),
    .go_2          (go_2),
    .ovf           (ovf)
  );

  always #5 de_clk = ~de_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    check("rdy_1",   32'(rdy_1),         32'(q.size() < QD));
    check("busy_2",  32'(busy_2),        32'(m_busy));
    check("go_2",    32'(go_2),          32'(m_go));
    check("ovf",     32'(ovf),           32'(m_ovf));
    check("sorg_2",  mf_sorg_2,          m_s2[66:35]);
    check("dorg_2",  mf_dorg_2,          m_s2[34:3]);
    check("ps_sel2", 32'(ps_sel_2),      32'(m_s2[2:1]));
    check("sd_sel2", 32'(sd_selector_2), 32'(m_s2[0]));
  endtask

  task automatic model_reset();
    q.delete();
    m_s2 = '0; m_busy = 0; m_go = 0; m_ovf = 0;
  endtask

  // One clock edge of the command pipeline as described by its rules.
  task automatic model_edge(input bit p, input logic [66:0] e, input bit dn);
    int occ = q.size();
    bit take;
    take = (!m_busy || dn) && occ > 0;
    if (p && occ == QD) m_ovf = 1;
    m_go = take;
    if (take) begin
      m_s2   = q.pop_front();
      m_busy = 1;
    end else if (dn) begin
      m_busy = 0;
    end
    if (p && occ < QD) q.push_back(e);
  endtask

  task automatic cyc(input bit p, input logic [31:0] s, input logic [31:0] d,
                     input logic [1:0] ps, input bit sd, input bit dn);
    push_1 = p; sorg_1 = s; dorg_1 = d; ps_sel_1 = ps; sd_sel_1 = sd; done_2 = dn;
    @(posedge de_clk);
    model_edge(p, {s, d, ps, sd}, dn);
    @(negedge de_clk);
    push_1 = 0; done_2 = 0;
    check_all();
  endtask

  task automatic rand_push(input bit dn);
    cyc(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), dn);
  endtask

  initial begin
    de_rstn = 0; push_1 = 0; sorg_1 = 0; dorg_1 = 0; ps_sel_1 = 0; sd_sel_1 = 0; done_2 = 0;
    model_reset();
    #1 check_all();
    @(negedge de_clk);
    check_all();
    de_rstn = 1;

    // Single command latency: outputs and go_2 two edges after the push.
    cyc(1'b1, 32'h0000_1230, 32'h0000_4560, 2'b01, 1'b1, 1'b0);
    check("lat_go_n1", 32'(go_2), 32'd0);
    cyc(1'b0, 0, 0, 0, 0, 1'b0);
    check("lat_sorg", mf_sorg_2, 32'h0000_1230);
    check("lat_ps",   32'(ps_sel_2), 32'd1);
    check("lat_go",   32'(go_2), 32'd1);
    check("lat_busy", 32'(busy_2), 32'd1);
    cyc(1'b0, 0, 0, 0, 0, 1'b0);
    check("go_once", 32'(go_2), 32'd0);

    // Fill the queue behind the active command, then overflow it.
    rand_push(1'b0);
    rand_push(1'b0);
    check("full_rdy", 32'(rdy_1), 32'd0);
    cyc(1'b1, 32'hDEAD_BEEF, 32'hBAD0_BAD0, 2'b11, 1'b1, 1'b0);
    check("ovf_set", 32'(ovf), 32'd1);

    // Drain one: next entry loads in order, rdy_1 rises.
    cyc(1'b0, 0, 0, 0, 0, 1'b1);
    check("drain_rdy", 32'(rdy_1), 32'd1);
    cyc(1'b0, 0, 0, 0, 0, 1'b0);
    cyc(1'b0, 0, 0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 0, 0, 1'b0);
    // Empty queue: done_2 clears busy_2 and holds data; a second done is ignored.
    cyc(1'b0, 0, 0, 0, 0, 1'b1);
    check("idle_busy", 32'(busy_2), 32'd0);
    cyc(1'b0, 0, 0, 0, 0, 1'b1);

    // Push with done_2 while one entry waits, across pointer wrap.
    rand_push(1'b0);
    rand_push(1'b0);
    cyc(1'b0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rand_push(1'b1);
      check("wrap_occ", 32'(q.size()), 32'd1);
    end

    // Mixed random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 6) rand_push(1'($urandom_range(0, 2) == 0));
      else cyc(1'b0, 0, 0, 0, 0, 1'($urandom_range(0, 2) == 0));
    end

    // Asynchronous reset mid-burst with two entries queued and stage 2 busy.
    cyc(1'b0, 0, 0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 0, 0, 1'b1);
    rand_push(1'b0);
    rand_push(1'b0);
    rand_push(1'b0);
    cyc(1'b0, 0, 0, 0, 0, 1'b0);
    check("pre_rst_busy", 32'(busy_2), 32'd1);
    #2 de_rstn = 0;
    #1 model_reset();
    check_all();
    check("rst_sorg", mf_sorg_2, 32'd0);
    @(negedge de_clk);
    check_all();
    de_rstn = 1;
    cyc(1'b0, 0, 0, 0, 0, 1'b1);
    check("post_rst_busy", 32'(busy_2), 32'd0);
    cyc(1'b0, 0, 0, 0, 0, 1'b0);
    // First push right after release is accepted.
    cyc(1'b1, 32'hCAFE_0001, 32'h0000_0002, 2'b10, 1'b0, 1'b0);
    cyc(1'b0, 0, 0, 0, 0, 1'b0);
    check("post_rst_sorg", mf_sorg_2, 32'hCAFE_0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/der_org_stage.md
DER_ORG_STAGE -- requirements
Module: der_org_stage

Interface
REQ-001 Parameter: QDEPTH, default 2, number of stage-1 command queue entries (power of two, 2..4).
REQ-002 de_clk  input  1  drawing engine clock; single clock domain for all state.
REQ-003 de_rstn  input  1  asynchronous, active-low reset.
REQ-004 push_1  input  1  stage-1 command go; captures the stage-1 snapshot.
REQ-005 sorg_1, dorg_1  input  32 each  multi-function source/destination origin, stage 1.
REQ-006 ps_sel_1  input  2  pixel-size select, stage 1 (buf_ctrl[10:9]).
REQ-007 sd_sel_1  input  1  source/destination selector, stage 1 (buf_ctrl[4]).
REQ-008 done_2  input  1  single-cycle pulse from the engine: the stage-2 command is complete.
REQ-009 rdy_1  output  1  queue not full; push_1 is accepted only when high.
REQ-010 mf_sorg_2, mf_dorg_2  output  32 each  registered stage-2 origins.
REQ-011 ps_sel_2  output  2  registered stage-2 pixel-size select.
REQ-012 sd_selector_2  output  1  registered stage-2 selector.
REQ-013 busy_2  output  1  stage-2 holds an active command.
REQ-014 go_2  output  1  one-cycle pulse in the cycle the stage-2 registers first show a new command.
REQ-015 ovf  output  1  sticky; set by push_1 while rdy_1 is low.

Function
REQ-016 The block SHALL form a QDEPTH-entry FIFO holding {sorg, dorg, ps_sel, sd_sel} (67 bits), followed by one stage-2 output register.
REQ-017 An accepted push_1 SHALL write the entry at the write pointer; pointers SHALL be log2(QDEPTH)+1 bits and wrap modulo 2*QDEPTH.
REQ-018 Full/empty SHALL be decided by pointer compare; rdy_1 = ~full, registered-pointer-derived with no combinational path from push_1.
REQ-019 A push_1 while full SHALL be dropped, SHALL leave queue contents unchanged, and SHALL set ovf.
REQ-020 Stage-2 load condition is (~busy_2 | done_2) & ~empty; on load, the head entry moves to the stage-2 registers, the read pointer advances, busy_2=1 and go_2=1 in the following cycle.
REQ-021 done_2 with an empty queue SHALL clear busy_2; the stage-2 data outputs SHALL hold their last value.
REQ-022 Latency: push_1 into an empty queue with busy_2=0 at cycle N SHALL give new stage-2 outputs and go_2 at cycle N+2.
REQ-023 Simultaneous push and load while full SHALL be rejected (rdy_1 is low that cycle); simultaneous push and load while not full SHALL both complete with occupancy unchanged.
REQ-024 done_2 while busy_2=0 SHALL be ignored.
REQ-025 There SHALL be no bypass from stage-1 inputs to stage-2 outputs; all outputs are registered.

Reset
REQ-026 While de_rstn=0: pointers=0, rdy_1=1, busy_2=0, go_2=0, ovf=0, mf_sorg_2=mf_dorg_2=0, ps_sel_2=0, sd_selector_2=0.
REQ-027 Reset asserted mid-operation SHALL discard all queued and active commands immediately (asynchronously); queue RAM contents need not be cleared.
REQ-028 The first push_1 after deassertion SHALL be accepted in the first de_clk edge after de_rstn rises.

Structure
REQ-029 The command-entry record width (67), field offsets and the QDEPTH default SHALL live in the shared drawing-engine package.
REQ-030 The FIFO SHALL be one sub-module, der_org_fifo (storage, pointers, full/empty); der_org_stage holds the stage-2 register, busy/go and ovf.

Verification
REQ-031 Reset, then push sorg=0x0000_1230, dorg=0x0000_4560, ps_sel=01, sd=1 -> at N+2: mf_sorg_2=0x0000_1230, ps_sel_2=01, go_2 pulse, busy_2=1.
REQ-032 Hold done_2 low and push 3 commands with QDEPTH=2 -> the first goes to stage 2, the next 2 fill the queue, rdy_1=0; a 4th push sets ovf and queue contents are unchanged.
REQ-033 With the queue full, pulse done_2 -> the next entry loads in order, rdy_1 rises the following cycle, go_2 pulses once.
REQ-034 Push on the same cycle as done_2 with 1 entry queued -> both complete, occupancy stays 1, and the data order is preserved across pointer wrap (8 pushes/pops).
REQ-035 Assert de_rstn low mid-burst with 2 entries queued and busy_2=1 -> all outputs return to REQ-026 values without a clock; a later done_2 has no effect.
